// File: rtl/mem_copy_pkg.sv
// Shared definitions for the block-copy engine: FSM state encoding and default widths.
package mem_copy_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Bus-master block copy: one read/write pair per byte, forward order, addresses wrap modulo 2^A.
// Optional running byte checksum enabled with MEM_COPY_CHECKSUM_EN.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int A = ADDR_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A:0]   Len,
  output logic         Busy,
  output logic         Done,
  output logic [A-1:0] MemAddress,
  output logic         MemWriteEn,
  output logic [W-1:0] MemWrData,
  input  logic [W-1:0] MemRdData
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [W-1:0] Checksum
`endif
);

  state_t       state_reg, state_next;
  logic [A-1:0] src_reg, src_next;
  logic [A-1:0] dst_reg, dst_next;
  logic [A:0]   len_reg, len_next;
  logic [A:0]   idx_reg, idx_next;
  logic [W-1:0] buf_reg, buf_next;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [W-1:0] csum_reg, csum_next;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
      idx_reg   <= '0;
      buf_reg   <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      buf_reg   <= buf_next;
`ifdef MEM_COPY_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  // Memory-facing outputs decode registered state only, so reset drops them immediately.
  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    buf_next   = buf_reg;
`ifdef MEM_COPY_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    Done       = 1'b0;
    MemAddress = '0;
    MemWriteEn = 1'b0;
    MemWrData  = '0;

    case (state_reg)
      IDLE: begin
        if (Start) begin
          src_next   = SrcAddr;
          dst_next   = DstAddr;
          len_next   = Len;
          idx_next   = '0;
`ifdef MEM_COPY_CHECKSUM_EN
          csum_next  = '0;
`endif
          state_next = (Len == '0) ? DONE : READ;
        end
      end
      READ: begin
        MemAddress = src_reg + idx_reg[A-1:0];
        buf_next   = MemRdData;
`ifdef MEM_COPY_CHECKSUM_EN
        csum_next  = csum_reg + MemRdData;
`endif
        state_next = WRITE;
      end
      WRITE: begin
        MemAddress = dst_reg + idx_reg[A-1:0];
        MemWriteEn = 1'b1;
        MemWrData  = buf_reg;
        idx_next   = idx_reg + (A+1)'(1);
        state_next = (idx_next == len_reg) ? DONE : READ;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state_reg != IDLE);

`ifdef MEM_COPY_CHECKSUM_EN
  assign Checksum = csum_reg;
`endif

endmodule
